// File: rtl/ir_decoder.sv
// ir_decoder: NEC IR frame receiver; times mark/space symbols and recovers 32-bit commands
module ir_decoder #(
  parameter int TICK_DIV = 1758,
  parameter bit ACTIVE_HIGH = 1'b1,
  parameter bit CHECK_INV = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  output logic [31:0] cmd,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        rpt,
  output logic        err,
  output logic        ovf,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_STOP} state_t;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_t state, state_n;
  logic [2:0] sync;
  logic [PW-1:0] pre;
  logic [7:0] dur;
  logic [31:0] sr, sr_n, cmd_n;
  logic [5:0] cnt, cnt_n;
  logic cmd_valid_n, rpt_n, err_n, ovf_n, fail, done;
  logic chg, mark, lm, ls, rs, bm, s0, s1;
  function automatic logic in_win(input logic [7:0] d, input logic [7:0] lo, input logic [7:0] hi);
    return d >= lo && d <= hi;
  endfunction
  assign chg  = sync[1] ^ sync[2];
  assign mark = sync[1] == ACTIVE_HIGH;
  assign busy = state != IDLE;
  assign lm = in_win(dur, 8'd112, 8'd144);
  assign ls = in_win(dur, 8'd56, 8'd72);
  assign rs = in_win(dur, 8'd28, 8'd36);
  assign bm = in_win(dur, 8'd5, 8'd11);
  assign s0 = in_win(dur, 8'd5, 8'd11);
  assign s1 = in_win(dur, 8'd20, 8'd28);
  // Synchroniser resets to the mark level so a line already in mark is not taken as a mark start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {3{ACTIVE_HIGH}};
      pre <= '0;
      dur <= '0;
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      cmd <= '0;
      cmd_valid <= 1'b0;
      rpt <= 1'b0;
      err <= 1'b0;
      ovf <= 1'b0;
    end else begin
      sync <= {sync[1:0], ir_in};
      if (chg) begin
        pre <= '0;
        dur <= '0;
      end else if (pre == PW'(TICK_DIV - 1)) begin
        pre <= '0;
        dur <= dur + 8'(dur != 8'hff);
      end else begin
        pre <= pre + PW'(1);
      end
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
      cmd <= cmd_n;
      cmd_valid <= cmd_valid_n;
      rpt <= rpt_n;
      err <= err_n;
      ovf <= ovf_n;
    end
  end
  always_comb begin
    state_n = state;
    sr_n = sr;
    cnt_n = cnt;
    cmd_n = cmd;
    cmd_valid_n = cmd_valid & ~cmd_ready;
    rpt_n = 1'b0;
    err_n = 1'b0;
    ovf_n = 1'b0;
    fail = 1'b0;
    done = 1'b0;
    if (state == IDLE) begin
      if (chg && mark) state_n = LEAD_MARK;
    end else if (chg) begin
      case (state)
        LEAD_MARK:  if (lm) state_n = LEAD_SPACE; else fail = 1'b1;
        LEAD_SPACE: begin
          cnt_n = '0;
          state_n = ls ? BIT_MARK : RPT_STOP;
          fail = !ls && !rs;
        end
        BIT_MARK:   if (bm) state_n = BIT_SPACE; else fail = 1'b1;
        BIT_SPACE: begin
          sr_n = {sr[30:0], s1};
          cnt_n = cnt + 6'd1;
          state_n = cnt == 6'd31 ? STOP_MARK : BIT_MARK;
          fail = !s0 && !s1;
        end
        STOP_MARK:  if (bm) done = 1'b1; else fail = 1'b1;
        RPT_STOP:   if (bm) begin rpt_n = 1'b1; state_n = IDLE; end else fail = 1'b1;
        default:    fail = 1'b1;
      endcase
    end else if (dur == 8'hff) begin
      fail = 1'b1;
    end
    if (done) begin
      state_n = IDLE;
      if (CHECK_INV && sr[23:16] != ~sr[31:24]) fail = 1'b1;
      else if (!cmd_valid || cmd_ready) begin
        cmd_n = sr;
        cmd_valid_n = 1'b1;
      end else ovf_n = 1'b1;
    end
    if (fail) begin
      err_n = 1'b1;
      state_n = IDLE;
      sr_n = '0;
      cnt_n = '0;
    end
  end
endmodule

// File: tb/tb_ir_decoder.sv
// tb_ir_decoder: drives NEC waveforms into two decoders (active-high/no-check, active-low/inverse-check)
module tb_ir_decoder;
  localparam int D = 2;
  logic clk = 1'b0, rst = 1'b1, ir = 1'b0, cmd_ready = 1'b0;
  logic [31:0] cmd [2];
  logic cmd_valid [2], rpt [2], err [2], ovf [2], busy [2];
  logic [31:0] exp_cmd [2];
  logic exp_valid [2];
  int exp_err [2], exp_ovf [2], exp_rpt [2];
  int n_err [2], n_ovf [2], n_rpt [2];
  int ntests = 0, nfail = 0;
  always #5 clk = ~clk;
  ir_decoder #(.TICK_DIV(D), .ACTIVE_HIGH(1'b1), .CHECK_INV(1'b0)) u0 (
    .clk(clk), .rst(rst), .ir_in(ir), .cmd(cmd[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready),
    .rpt(rpt[0]), .err(err[0]), .ovf(ovf[0]), .busy(busy[0]));
  ir_decoder #(.TICK_DIV(D), .ACTIVE_HIGH(1'b0), .CHECK_INV(1'b1)) u1 (
    .clk(clk), .rst(rst), .ir_in(~ir), .cmd(cmd[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready),
    .rpt(rpt[1]), .err(err[1]), .ovf(ovf[1]), .busy(busy[1]));
  initial begin
    n_err = '{0, 0};
    n_ovf = '{0, 0};
    n_rpt = '{0, 0};
  end
  always @(negedge clk) for (int i = 0; i < 2; i++) begin
    n_err[i] += int'(err[i]);
    n_ovf[i] += int'(ovf[i]);
    n_rpt[i] += int'(rpt[i]);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic int r(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction
  // Level held t ticks; the decoder measures t-1 after the edge-clear, so send ranges sit inside the windows
  task automatic seg(input logic lv, input int t);
    ir = lv;
    repeat (t * D) @(negedge clk);
  endtask
  task automatic bits(input logic [31:0] w, input int n);
    for (int k = 31; k > 31 - n; k--) begin
      seg(1'b1, r(7, 11));
      seg(1'b0, w[k] ? r(22, 28) : r(7, 11));
    end
  endtask
  task automatic send_frame(input logic [31:0] w);
    seg(1'b1, r(114, 144));
    seg(1'b0, r(58, 72));
    bits(w, 32);
    seg(1'b1, r(7, 11));
    ir = 1'b0;
    repeat (10) @(negedge clk);
  endtask
  task automatic model_frame(input logic [31:0] w, input logic rdy);
    for (int i = 0; i < 2; i++) begin
      if (i == 1 && w[23:16] != ~w[31:24]) exp_err[i]++;
      else if (!exp_valid[i] || rdy) begin
        exp_cmd[i] = w;
        exp_valid[i] = 1'b1;
      end else exp_ovf[i]++;
      if (rdy) exp_valid[i] = 1'b0;
    end
  endtask
  task automatic accept();
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    exp_valid = '{1'b0, 1'b0};
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ntests++;
      if ({cmd[i], cmd_valid[i], rpt[i], err[i], ovf[i], busy[i]} !== 37'b0) begin
        nfail++;
        $display("FAIL reset dut%0d: got %h,%b%b%b%b%b want all zero", i, cmd[i], cmd_valid[i], rpt[i], err[i], ovf[i], busy[i]);
      end
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_loopback();
    send_frame(32'hFB040707);
    model_frame(32'hFB040707, 1'b0);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ntests++;
      if (cmd[i] !== 32'hFB040707) begin nfail++; $display("FAIL loopback_cmd dut%0d: got %h want %h", i, cmd[i], 32'hFB040707); end
      ntests++;
      if (cmd_valid[i] !== 1'b1) begin nfail++; $display("FAIL loopback_valid dut%0d: got %b want 1", i, cmd_valid[i]); end
    end
    accept();
    for (int i = 0; i < 2; i++) begin
      ntests++;
      if (cmd_valid[i] !== 1'b0) begin nfail++; $display("FAIL accept_clear dut%0d: got %b want 0", i, cmd_valid[i]); end
      ntests++;
      if (n_err[i] !== exp_err[i]) begin nfail++; $display("FAIL loopback_err dut%0d: got %0d want %0d", i, n_err[i], exp_err[i]); end
    end
  endtask
  task automatic test_repeat();
    seg(1'b1, 128);
    seg(1'b0, 32);
    seg(1'b1, 8);
    ir = 1'b0;
    repeat (10) @(negedge clk);
    exp_rpt = '{exp_rpt[0] + 1, exp_rpt[1] + 1};
    for (int i = 0; i < 2; i++) begin
      ntests++;
      if (n_rpt[i] !== exp_rpt[i]) begin nfail++; $display("FAIL repeat_pulse dut%0d: got %0d cycles want %0d", i, n_rpt[i], exp_rpt[i]); end
      ntests++;
      if (busy[i] !== 1'b0) begin nfail++; $display("FAIL repeat_busy dut%0d: got %b want 0", i, busy[i]); end
      ntests++;
      if ({cmd[i], cmd_valid[i]} !== {exp_cmd[i], exp_valid[i]}) begin
        nfail++; $display("FAIL repeat_cmd dut%0d: got %h/%b want %h/%b", i, cmd[i], cmd_valid[i], exp_cmd[i], exp_valid[i]);
      end
    end
  endtask
  task automatic test_bad_leader();
    seg(1'b1, 96);
    ir = 1'b0;
    repeat (10) @(negedge clk);
    exp_err = '{exp_err[0] + 1, exp_err[1] + 1};
    for (int i = 0; i < 2; i++) begin
      ntests++;
      if (n_err[i] !== exp_err[i]) begin nfail++; $display("FAIL bad_leader_err dut%0d: got %0d want %0d", i, n_err[i], exp_err[i]); end
      ntests++;
      if (cmd_valid[i] !== 1'b0) begin nfail++; $display("FAIL bad_leader_valid dut%0d: got %b want 0", i, cmd_valid[i]); end
    end
    repeat (20) @(negedge clk);
    send_frame(32'h12345678);
    model_frame(32'h12345678, 1'b0);
    for (int i = 0; i < 2; i++) begin
      ntests++;
      if ({cmd[i], cmd_valid[i]} !== {exp_cmd[i], exp_valid[i]}) begin
        nfail++; $display("FAIL after_bad_cmd dut%0d: got %h/%b want %h/%b", i, cmd[i], cmd_valid[i], exp_cmd[i], exp_valid[i]);
      end
      ntests++;
      if (n_err[i] !== exp_err[i]) begin nfail++; $display("FAIL after_bad_err dut%0d: got %0d want %0d", i, n_err[i], exp_err[i]); end
    end
    accept();
  endtask
  task automatic test_timeout();
    int k;
    seg(1'b1, 128);
    seg(1'b0, 64);
    bits(32'hA5A5A5A5, 9);
    seg(1'b1, 8);
    ir = 1'b0;
    ntests++;
    if (busy[0] !== 1'b1) begin nfail++; $display("FAIL timeout_busy_before: got %b want 1", busy[0]); end
    for (k = 0; k < 800 && !err[0]; k++) @(negedge clk);
    ntests++;
    if (k < 500 || k > 530) begin nfail++; $display("FAIL timeout_latency: got %0d cycles want 500..530", k); end
    exp_err = '{exp_err[0] + 1, exp_err[1] + 1};
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ntests++;
      if (n_err[i] !== exp_err[i]) begin nfail++; $display("FAIL timeout_err dut%0d: got %0d want %0d", i, n_err[i], exp_err[i]); end
      ntests++;
      if ({busy[i], cmd_valid[i]} !== 2'b00) begin nfail++; $display("FAIL timeout_idle dut%0d: got busy/valid %b%b want 00", i, busy[i], cmd_valid[i]); end
    end
  endtask
  task automatic test_overflow();
    send_frame(32'hFB040707);
    model_frame(32'hFB040707, 1'b0);
    send_frame(32'h01FE00FF);
    model_frame(32'h01FE00FF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      ntests++;
      if (n_ovf[i] !== exp_ovf[i]) begin nfail++; $display("FAIL ovf_pulse dut%0d: got %0d want %0d", i, n_ovf[i], exp_ovf[i]); end
      ntests++;
      if ({cmd[i], cmd_valid[i]} !== {exp_cmd[i], exp_valid[i]}) begin
        nfail++; $display("FAIL ovf_cmd dut%0d: got %h/%b want %h/%b", i, cmd[i], cmd_valid[i], exp_cmd[i], exp_valid[i]);
      end
    end
    accept();
    send_frame(32'hFB050707);
    model_frame(32'hFB050707, 1'b0);
    for (int i = 0; i < 2; i++) begin
      ntests++;
      if (n_err[i] !== exp_err[i]) begin nfail++; $display("FAIL inv_err dut%0d: got %0d want %0d", i, n_err[i], exp_err[i]); end
      ntests++;
      if ({cmd[i], cmd_valid[i]} !== {exp_cmd[i], exp_valid[i]}) begin
        nfail++; $display("FAIL inv_cmd dut%0d: got %h/%b want %h/%b", i, cmd[i], cmd_valid[i], exp_cmd[i], exp_valid[i]);
      end
    end
    accept();
  endtask
  task automatic test_random();
    logic [31:0] w;
    logic rdy;
    repeat (4) begin
      w = $urandom;
      if ($urandom_range(1, 0) == 1) w[23:16] = ~w[31:24];
      rdy = 1'($urandom_range(1, 0));
      cmd_ready = rdy;
      send_frame(w);
      model_frame(w, rdy);
      cmd_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        ntests++;
        if ({cmd[i], cmd_valid[i]} !== {exp_cmd[i], exp_valid[i]}) begin
          nfail++; $display("FAIL random_cmd dut%0d: got %h/%b want %h/%b", i, cmd[i], cmd_valid[i], exp_cmd[i], exp_valid[i]);
        end
        ntests++;
        if ({n_err[i], n_ovf[i]} !== {exp_err[i], exp_ovf[i]}) begin
          nfail++; $display("FAIL random_events dut%0d: got err %0d ovf %0d want err %0d ovf %0d", i, n_err[i], n_ovf[i], exp_err[i], exp_ovf[i]);
        end
      end
    end
  endtask
  task automatic test_reset_midframe();
    seg(1'b1, 128);
    seg(1'b0, 64);
    bits(32'h5AC3F00F, 17);
    ir = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      ntests++;
      if ({cmd[i], cmd_valid[i], rpt[i], err[i], ovf[i], busy[i]} !== 37'b0) begin
        nfail++;
        $display("FAIL midframe_reset dut%0d: got %h,%b%b%b%b%b want all zero", i, cmd[i], cmd_valid[i], rpt[i], err[i], ovf[i], busy[i]);
      end
    end
    exp_cmd = '{32'h0, 32'h0};
    exp_valid = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    seg(1'b1, 20);
    seg(1'b0, 40);
    send_frame(32'h20DF10EF);
    model_frame(32'h20DF10EF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      ntests++;
      if ({cmd[i], cmd_valid[i]} !== {exp_cmd[i], exp_valid[i]}) begin
        nfail++; $display("FAIL post_reset_cmd dut%0d: got %h/%b want %h/%b", i, cmd[i], cmd_valid[i], exp_cmd[i], exp_valid[i]);
      end
      ntests++;
      if (n_err[i] !== exp_err[i]) begin nfail++; $display("FAIL post_reset_err dut%0d: got %0d want %0d", i, n_err[i], exp_err[i]); end
    end
  endtask
  initial begin
    exp_cmd = '{32'h0, 32'h0};
    exp_valid = '{1'b0, 1'b0};
    exp_err = '{0, 0};
    exp_ovf = '{0, 0};
    exp_rpt = '{0, 0};
    test_reset();
    test_loopback();
    test_repeat();
    test_bad_leader();
    test_timeout();
    test_overflow();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/ir_decoder.md
Name: ir_decoder

Overview:
- NEC-style IR frame receiver; the downstream stage of ir_encoder. Consumes the demodulated IR envelope (ir_encoder's ir_output, or an external IR receiver) and recovers the 32-bit command word.
- Measures mark/space durations with a tick prescaler and classifies them into leader, repeat, 0 and 1 symbols.
- Presents decoded commands on a valid/ready output port; reports repeat codes, errors and overflow as single-cycle pulses.

Parameters:
- TICK_DIV, 1758, clk cycles per tick (1/8 NEC unit of 562.5 us at 25 MHz); the bench uses small values for speed.
- ACTIVE_HIGH, 1, 1: ir_in high = mark; 0: ir_in low = mark.
- CHECK_INV, 0, 1: require cmd[23:16] == ~cmd[31:24] or flag an error.

Ports:
- clk  in  1  system clock, 25 MHz nominal
- rst  in  1  asynchronous, active-high reset
- ir_in  in  1  IR envelope, asynchronous to clk
- cmd  out  32  decoded command, first received bit in cmd[31] (matches ir_encoder transmit order)
- cmd_valid  out  1  cmd holds an unconsumed frame
- cmd_ready  in  1  consumer accepts cmd when high together with cmd_valid
- rpt  out  1  one-cycle pulse on a valid repeat code
- err  out  1  one-cycle pulse on a malformed symbol or timeout
- ovf  out  1  one-cycle pulse when a complete frame is dropped
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: cmd=0, cmd_valid=0, rpt=0, err=0, ovf=0, busy=0, state=IDLE, tick counter=0.
- Input conditioning:
  - ir_in passes through a 2-flop synchroniser, then a third flop for edge detection; ACTIVE_HIGH is applied after synchronisation.
  - Edge-to-state latency is 3 clk from the first sampling edge that sees the new level.
- Timing:
  - Prescaler counts 0..TICK_DIV-1 and emits a tick on wrap.
  - Duration counter dur (8 bit) increments per tick and saturates at 255.
  - On every synchronised edge, dur is evaluated, then prescaler and dur both clear to 0.
- Windows (inclusive, in ticks):
  - LM (leader mark) 112..144
  - LS (leader space) 56..72
  - RS (repeat space) 28..36
  - BM (bit/stop mark) 5..11
  - S0 (zero space) 5..11
  - S1 (one space) 20..28
- States:
  - IDLE: on mark start -> LEAD_MARK.
  - LEAD_MARK: on mark end, dur in LM -> LEAD_SPACE, else error.
  - LEAD_SPACE: on space end, dur in LS -> BIT_MARK with bit count=0; dur in RS -> RPT_STOP; else error.
  - BIT_MARK: on mark end, dur in BM -> BIT_SPACE, else error.
  - BIT_SPACE: on space end, shift in 0 (S0) or 1 (S1) at the LSB, shifting the register left; increment count; at count 32 -> STOP_MARK, else -> BIT_MARK. Any other dur -> error.
  - STOP_MARK: on mark end, dur in BM -> frame complete -> IDLE, else error.
  - RPT_STOP: on mark end, dur in BM -> rpt pulse -> IDLE, else error.
- Error: err pulses once, state -> IDLE, shift register discarded, cmd/cmd_valid untouched.
- Timeout: dur reaches 255 in any state except IDLE -> error.
- Frame complete:
  - CHECK_INV=1 and the inverse check fails -> error.
  - cmd_valid=0 or (cmd_valid & cmd_ready) in the same cycle -> cmd loads, cmd_valid=1.
  - Otherwise the frame is dropped, ovf pulses, and cmd keeps its old value.
- Handshake:
  - cmd_valid stays high and cmd stable until a cycle with cmd_ready=1; cmd_valid then clears on the next edge unless a new frame loads in that same cycle.
  - cmd_ready is ignored when cmd_valid=0.
- Simultaneous events: rpt, err and ovf are mutually exclusive per frame; rpt never alters cmd_valid.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.
- After reset, if ir_in is already in mark, the decoder waits in IDLE for the next mark start.

Test Plan:
- ir_encoder loopback (TICK_DIV scaled to match), cmd=0xFB040707, cmd_ready=0 -> cmd_valid=1 with cmd=0xFB040707, held stable; raise cmd_ready for 1 cycle -> cmd_valid=0 next cycle.
- Repeat code: 128-tick mark, 32-tick space, 8-tick mark -> rpt high exactly 1 cycle, busy low afterwards, cmd_valid/cmd unchanged.
- 96-tick leader mark -> err pulse, no cmd_valid; a following good frame 0x12345678 decodes correctly.
- Valid leader plus 10 bits, then line idle -> err pulse when dur hits 255 ticks; state returns to IDLE, no cmd_valid.
- Two good frames (0xFB040707, then 0x01FE00FF) with cmd_ready=0 -> ovf pulse at the second stop mark, cmd still 0xFB040707; with CHECK_INV=1, 0xFB050707 -> err, no cmd_valid.
- rst asserted at bit 17 -> all outputs 0 asynchronously; after release, the next full frame decodes.
